// File: rtl/mpmc11_pkg.sv
// ---------------------------------------------------------------------------
// mpmc11_pkg
// Shared types and constants for the mpmc11 memory controller slice.
// Holds the read-data collector state encoding and the default line
// buffer depth (in app_rd_data strips).
// ---------------------------------------------------------------------------
package mpmc11_pkg;

   // Default number of strips a single read line can hold.
   localparam int MPMC11_MAX_STRIPS = 8;

   // Read-data collector states.
   typedef enum logic [1:0] {
      RDC_IDLE,
      RDC_COLLECT,
      RDC_FIN
   } mpmc11_rdc_state_t;

endpackage

// File: rtl/mpmc11_tmo_counter.sv
// ---------------------------------------------------------------------------
// mpmc11_tmo_counter
// Idle-cycle watchdog for the read-data collector. Counts cycles while
// en_i is high and raises hit_o once TMO-1 idle cycles have been seen, so
// the owner aborts on the TMO-th consecutive idle cycle.
// Ports:
//   clk     controller clock
//   rstn    asynchronous active-low reset
//   clear_i synchronous clear (wins over en_i)
//   en_i    count enable (one idle cycle)
//   hit_o   counter has reached TMO-1
// ---------------------------------------------------------------------------
module mpmc11_tmo_counter #(
   parameter int TMO = 1023
) (
   input  logic clk,
   input  logic rstn,
   input  logic clear_i,
   input  logic en_i,
   output logic hit_o
);

   localparam int            CW   = (TMO > 1) ? $clog2(TMO) : 1;
   localparam logic [CW-1:0] LAST = CW'(TMO - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign hit_o = (cnt_q == LAST);

   // Next count: clear has priority; the count parks at LAST so it never
   // wraps while the owner is reacting to the hit.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && !hit_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mpmc11_app_rd_data_collect.sv
// ---------------------------------------------------------------------------
// mpmc11_app_rd_data_collect
// Captures MIG app_rd_data strips after a read command is accepted, builds
// them into a line buffer, counts them against num_strips, pulses done when
// the read finishes and keeps a sticky err for stray, malformed, oversized
// or timed-out reads.
// Ports:
//   clk, rstn        MIG ui_clk, asynchronous active-low reset
//   start            1-cycle pulse: read command accepted
//   num_strips       index of the last strip of this read
//   rd_valid/rd_end  app_rd_data_valid / app_rd_data_end
//   rd_data          app_rd_data strip
//   line_o           assembled line, strip n at [n*WID +: WID]
//   strip_cnt        strips captured in the current read
//   busy             collecting
//   done             1-cycle completion pulse (good or error)
//   err              sticky error, cleared by the next accepted start
// ---------------------------------------------------------------------------
module mpmc11_app_rd_data_collect
   import mpmc11_pkg::*;
#(
   parameter int WID        = 128,
   parameter int MAX_STRIPS = MPMC11_MAX_STRIPS,
   parameter int TMO        = 1023
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start,
   input  logic [5:0]                num_strips,
   input  logic                      rd_valid,
   input  logic                      rd_end,
   input  logic [WID-1:0]            rd_data,
   output logic [WID*MAX_STRIPS-1:0] line_o,
   output logic [5:0]                strip_cnt,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam int IW = (MAX_STRIPS > 1) ? $clog2(MAX_STRIPS) : 1;

   mpmc11_rdc_state_t                  state_q, state_d;
   logic [MAX_STRIPS-1:0][WID-1:0]     lineBuf_q, lineBuf_d;
   logic [5:0]                         stripCnt_q, stripCnt_d;
   logic [5:0]                         numStrips_q, numStrips_d;
   logic                               done_q, done_d;
   logic                               err_q, err_d;

   logic startTaken;
   logic startTooBig;
   logic isLast;
   logic tmoHit;
   logic tmoClear;
   logic tmoEn;

   // A start is only honoured outside COLLECT; in FIN it chains straight
   // into the next read without an IDLE bubble.
   assign startTaken  = start && (state_q != RDC_COLLECT);
   assign startTooBig = ({1'b0, num_strips} >= 7'(MAX_STRIPS));
   assign isLast      = (stripCnt_q == numStrips_q);
   assign tmoClear    = startTaken || ((state_q == RDC_COLLECT) && rd_valid);
   assign tmoEn       = (state_q == RDC_COLLECT) && !rd_valid;

   mpmc11_tmo_counter #(
      .TMO (TMO)
   ) u_tmo (
      .clk     (clk),
      .rstn    (rstn),
      .clear_i (tmoClear),
      .en_i    (tmoEn),
      .hit_o   (tmoHit)
   );

   // Next-state logic for the collector FSM, line buffer and flags. done is
   // produced here one cycle early so that the registered pulse lines up
   // with the FIN cycle.
   always_comb begin
      state_d     = state_q;
      lineBuf_d   = lineBuf_q;
      stripCnt_d  = stripCnt_q;
      numStrips_d = numStrips_q;
      done_d      = 1'b0;
      err_d       = err_q;

      case (state_q)
         RDC_IDLE, RDC_FIN: begin
            state_d = RDC_IDLE;
            if (startTaken) begin
               if (startTooBig) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  numStrips_d = num_strips;
                  stripCnt_d  = '0;
                  err_d       = 1'b0;
                  state_d     = RDC_COLLECT;
               end
            end
            // Stray beat: dropped, but it must poison err even when it
            // arrives together with a start that just cleared it.
            if (rd_valid) begin
               err_d = 1'b1;
            end
         end

         RDC_COLLECT: begin
            if (rd_valid) begin
               lineBuf_d[stripCnt_q[IW-1:0]] = rd_data;
               stripCnt_d                    = stripCnt_q + 6'd1;
               if (rd_end != isLast) begin
                  err_d = 1'b1;
               end
               if (isLast) begin
                  state_d = RDC_FIN;
                  done_d  = 1'b1;
               end
            end else if (tmoHit) begin
               err_d   = 1'b1;
               state_d = RDC_FIN;
               done_d  = 1'b1;
            end
         end

         default: begin
            state_d = RDC_IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any read in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= RDC_IDLE;
         lineBuf_q   <= '0;
         stripCnt_q  <= '0;
         numStrips_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         lineBuf_q   <= lineBuf_d;
         stripCnt_q  <= stripCnt_d;
         numStrips_q <= numStrips_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign line_o    = lineBuf_q;
   assign strip_cnt = stripCnt_q;
   assign busy      = (state_q == RDC_COLLECT);
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mpmc11_app_rd_data_collect.sv
// ---------------------------------------------------------------------------
// tb_mpmc11_app_rd_data_collect
// Self-checking bench for the read-data collector. Each read pushes its
// expected completion (strip count, err, line) to a scoreboard queue; a
// monitor pops and compares whenever done pulses.
// ---------------------------------------------------------------------------
module tb_mpmc11_app_rd_data_collect;

   localparam int WID  = 16;
   localparam int MAXS = 8;
   localparam int TMO  = 16;
   localparam int LW   = WID * MAXS;

   logic           clk        = 1'b0;
   logic           rstn       = 1'b0;
   logic           start      = 1'b0;
   logic [5:0]     num_strips = '0;
   logic           rd_valid   = 1'b0;
   logic           rd_end     = 1'b0;
   logic [WID-1:0] rd_data    = '0;
   logic [LW-1:0]  line_o;
   logic [5:0]     strip_cnt;
   logic           busy;
   logic           done;
   logic           err;

   typedef struct {
      string         tag;
      logic [5:0]    cnt;
      logic          errV;
      logic [LW-1:0] line;
      bit            chkData;
   } exp_t;

   exp_t           sbQ[$];
   logic [LW-1:0]  expLine = '0;
   logic [WID-1:0] beatData[MAXS];
   logic           beatEnd[MAXS];
   int             beatGap[MAXS];
   logic           prevDone = 1'b0;
   int             checks   = 0;
   int             errors   = 0;

   always #5 clk = ~clk;

   mpmc11_app_rd_data_collect #(
      .WID        (WID),
      .MAX_STRIPS (MAXS),
      .TMO        (TMO)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .num_strips (num_strips),
      .rd_valid   (rd_valid),
      .rd_end     (rd_end),
      .rd_data    (rd_data),
      .line_o     (line_o),
      .strip_cnt  (strip_cnt),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rstn) begin
         if (done) begin
            checkOutput("donePulse", LW'(prevDone), '0);
            checkOutput("doneBusy", LW'(busy), '0);
            checkOutput("sbHasEntry", LW'(sbQ.size() != 0), LW'(1));
            if (sbQ.size() != 0) begin
               exp_t e;
               e = sbQ.pop_front();
               checkOutput({e.tag, "_err"}, LW'(err), LW'(e.errV));
               if (e.chkData) begin
                  checkOutput({e.tag, "_stripCnt"}, LW'(strip_cnt), LW'(e.cnt));
                  checkOutput({e.tag, "_line"}, line_o, e.line);
               end
            end
         end
         prevDone = done;
      end else begin
         prevDone = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) tick();
   endtask

   task automatic issueStart(input logic [5:0] ns);
      start      = 1'b1;
      num_strips = ns;
      tick();
      start      = 1'b0;
   endtask

   // Builds the expected completion from the planned beats and queues it.
   task automatic pushExp(input string tag, input logic [5:0] ns, input int n,
                          input bit forceErr, input bit chkData);
      exp_t          e;
      logic [LW-1:0] ln;
      logic          eflag;
      ln    = expLine;
      eflag = forceErr;
      for (int i = 0; i < n; i++) begin
         ln[i*WID +: WID] = beatData[i];
         if (beatEnd[i] != (i == int'(ns))) eflag = 1'b1;
      end
      if (n < int'(ns) + 1) eflag = 1'b1;
      e.tag     = tag;
      e.cnt     = 6'(n);
      e.errV    = eflag;
      e.line    = ln;
      e.chkData = chkData;
      sbQ.push_back(e);
      if (chkData) expLine = ln;
   endtask

   // Drives n beats with the planned gaps; a short read is left to time out.
   task automatic driveBeats(input string tag, input logic [5:0] ns, input int n);
      for (int i = 0; i < n; i++) begin
         idleCycles(beatGap[i]);
         rd_valid = 1'b1;
         rd_data  = beatData[i];
         rd_end   = beatEnd[i];
         tick();
         rd_valid = 1'b0;
         rd_end   = 1'b0;
         checkOutput({tag, "_cntLive"}, LW'(strip_cnt), LW'(i + 1));
      end
      if (n == int'(ns) + 1) begin
         checkOutput({tag, "_doneLat"}, LW'(done), LW'(1));
      end else begin
         repeat (TMO - 1) tick();
         checkOutput({tag, "_tmoEarly"}, LW'(done), '0);
         tick();
         checkOutput({tag, "_tmoDone"}, LW'(done), LW'(1));
      end
   endtask

   task automatic applyStimulus();
      // Reset values.
      #12;
      checkOutput("rst_line", line_o, '0);
      checkOutput("rst_cnt", LW'(strip_cnt), '0);
      checkOutput("rst_busy", LW'(busy), '0);
      checkOutput("rst_done", LW'(done), '0);
      checkOutput("rst_err", LW'(err), '0);
      rstn = 1'b1;
      idleCycles(2);

      // Reset in the middle of a 4-strip read.
      issueStart(6'd3);
      beatData[0] = 16'h1111;
      beatData[1] = 16'h2222;
      for (int i = 0; i < 2; i++) begin
         rd_valid = 1'b1;
         rd_data  = beatData[i];
         tick();
         rd_valid = 1'b0;
      end
      checkOutput("mid_line", LW'(line_o[WID +: WID]), LW'(16'h2222));
      checkOutput("mid_busy", LW'(busy), LW'(1));
      #2 rstn = 1'b0;
      #1;
      checkOutput("arst_line", line_o, '0);
      checkOutput("arst_cnt", LW'(strip_cnt), '0);
      checkOutput("arst_busy", LW'(busy), '0);
      checkOutput("arst_done", LW'(done), '0);
      checkOutput("arst_err", LW'(err), '0);
      expLine = '0;
      #3 rstn = 1'b1;
      tick();

      // Four strips with assorted gaps.
      for (int i = 0; i < 4; i++) begin
         beatData[i] = WID'(16'h000A + i);
         beatEnd[i]  = (i == 3);
      end
      beatGap[0] = 0; beatGap[1] = 3; beatGap[2] = 5; beatGap[3] = 1;
      issueStart(6'd3);
      pushExp("t2", 6'd3, 4, 1'b0, 1'b1);
      driveBeats("t2", 6'd3, 4);
      tick();

      // Single-strip read.
      beatData[0] = 16'h3333; beatEnd[0] = 1'b1; beatGap[0] = 0;
      issueStart(6'd0);
      pushExp("t3", 6'd0, 1, 1'b0, 1'b1);
      driveBeats("t3", 6'd0, 1);
      tick();

      // Stray beat with no read outstanding.
      rd_valid = 1'b1; rd_data = 16'hBAD0; rd_end = 1'b1;
      tick();
      rd_valid = 1'b0; rd_end = 1'b0;
      checkOutput("stray_err", LW'(err), LW'(1));
      checkOutput("stray_busy", LW'(busy), '0);
      checkOutput("stray_line", line_o, expLine);
      idleCycles(3);

      // Stray beat in the same cycle as start: dropped, read continues.
      beatData[0] = 16'h5555; beatEnd[0] = 1'b1; beatGap[0] = 1;
      start = 1'b1; num_strips = 6'd0;
      rd_valid = 1'b1; rd_data = 16'hFFFF; rd_end = 1'b1;
      tick();
      start = 1'b0; rd_valid = 1'b0; rd_end = 1'b0;
      pushExp("t5s", 6'd0, 1, 1'b1, 1'b1);
      driveBeats("t5s", 6'd0, 1);
      tick();

      // One beat of two, then silence until the watchdog fires.
      beatData[0] = 16'h4444; beatEnd[0] = 1'b0; beatGap[0] = 2;
      issueStart(6'd1);
      pushExp("t4", 6'd1, 1, 1'b0, 1'b1);
      driveBeats("t4", 6'd1, 1);
      tick();

      // rd_end on the first of two beats.
      beatData[0] = 16'h6161; beatEnd[0] = 1'b1; beatGap[0] = 0;
      beatData[1] = 16'h6262; beatEnd[1] = 1'b1; beatGap[1] = 2;
      issueStart(6'd1);
      pushExp("t5b", 6'd1, 2, 1'b0, 1'b1);
      driveBeats("t5b", 6'd1, 2);
      tick();

      // Back-to-back: new start lands in the done cycle of the previous read.
      beatData[0] = 16'h7070; beatEnd[0] = 1'b1; beatGap[0] = 0;
      issueStart(6'd0);
      pushExp("t6a", 6'd0, 1, 1'b0, 1'b1);
      driveBeats("t6a", 6'd0, 1);
      for (int i = 0; i < 8; i++) begin
         beatData[i] = WID'(16'h8000 + i * 16'h0101);
         beatEnd[i]  = (i == 7);
         beatGap[i]  = i % 3;
      end
      issueStart(6'd7);
      pushExp("t6b", 6'd7, 8, 1'b0, 1'b1);
      driveBeats("t6b", 6'd7, 8);
      tick();

      // Oversized request: immediate error completion, no collection.
      pushExp("t6bad", 6'd8, 0, 1'b1, 1'b0);
      issueStart(6'd8);
      checkOutput("bad_done", LW'(done), LW'(1));
      checkOutput("bad_busy", LW'(busy), '0);
      tick();
      checkOutput("bad_doneGone", LW'(done), '0);
      checkOutput("bad_err", LW'(err), LW'(1));
      checkOutput("bad_idle", LW'(busy), '0);
      idleCycles(2);
   endtask

   initial begin
      for (int i = 0; i < MAXS; i++) begin
         beatData[i] = '0;
         beatEnd[i]  = 1'b0;
         beatGap[i]  = 0;
      end
      applyStimulus();
      checkOutput("sb_empty", LW'(sbQ.size()), '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
